// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/requester enums and counter sizing for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic [1:0] {REQ_NONE, REQ_DATA, REQ_EXT, REQ_IF} req_id_e;
  function automatic int cnt_w(input int lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: winner select; data always wins, then ext > fetch or, with MEM_ARB_RR_EN, ext/fetch alternate
module mem_arb_prio import mem_arb_pkg::*; (
  input  logic       d_req,
  input  logic       x_req,
  input  logic       if_req,
  input  logic       last_x,
  output logic [1:0] grant
);
`ifdef MEM_ARB_RR_EN
  // last_x=1 means ext was served last, so fetch wins a tie
  always_comb grant = d_req ? REQ_DATA : (if_req & (~x_req | last_x)) ? REQ_IF : x_req ? REQ_EXT : REQ_NONE;
`else
  logic unused_last_x;
  assign unused_last_x = last_x;
  always_comb grant = d_req ? REQ_DATA : x_req ? REQ_EXT : if_req ? REQ_IF : REQ_NONE;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory port among data, external loader and fetch.
// MEM_ARB_RR_EN: ext and fetch alternate below data instead of fixed ext > fetch.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  input  logic              x_req,
  input  logic              x_wr,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic [DATA_W-1:0] x_rdata,
  output logic              x_valid,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              if_stall
);
  localparam int CW = cnt_w(MEM_LAT);
  localparam logic [CW-1:0] LAT_LD = CW'(MEM_LAT);
  state_e state_q, state_d;
  req_id_e id_q, id_d;
  logic wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d, x_rdata_q, x_rdata_d, if_rdata_q, if_rdata_d;
  logic d_valid_q, d_valid_d, x_valid_q, x_valid_d, if_valid_q, if_valid_d;
  logic [1:0] grant;
  logic last_x;
  logic sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
`ifdef MEM_ARB_RR_EN
  logic last_x_q, last_x_d;
  assign last_x = last_x_q;
`else
  assign last_x = 1'b1;
`endif
  mem_arb_prio u_prio (
    .d_req  (d_req),
    .x_req  (x_req),
    .if_req (if_req),
    .last_x (last_x),
    .grant  (grant)
  );
  always_comb begin
    sel_wr    = (grant == REQ_DATA) ? d_wr    : (grant == REQ_EXT) ? x_wr    : 1'b0;
    sel_addr  = (grant == REQ_DATA) ? d_addr  : (grant == REQ_EXT) ? x_addr  : if_addr;
    sel_wdata = (grant == REQ_DATA) ? d_wdata : (grant == REQ_EXT) ? x_wdata : '0;
  end
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    d_rdata_d   = d_rdata_q;
    x_rdata_d   = x_rdata_q;
    if_rdata_d  = if_rdata_q;
    d_valid_d   = 1'b0;
    x_valid_d   = 1'b0;
    if_valid_d  = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_x_d    = last_x_q;
`endif
    unique case (state_q)
      IDLE: if (grant != REQ_NONE) begin
        // the address/data flops double as the transaction latch, so later field changes are ignored
        state_d     = ISSUE;
        id_d        = req_id_e'(grant);
        wr_d        = sel_wr;
        mem_en_d    = 1'b1;
        mem_wr_d    = sel_wr;
        mem_addr_d  = sel_addr;
        mem_wdata_d = sel_wdata;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = LAT_LD;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d    = RESP;
          d_valid_d  = id_q == REQ_DATA;
          x_valid_d  = id_q == REQ_EXT;
          if_valid_d = id_q == REQ_IF;
          d_rdata_d  = (!wr_q && id_q == REQ_DATA) ? mem_rdata : d_rdata_q;
          x_rdata_d  = (!wr_q && id_q == REQ_EXT)  ? mem_rdata : x_rdata_q;
          if_rdata_d = (!wr_q && id_q == REQ_IF)   ? mem_rdata : if_rdata_q;
        end
      end
      RESP: begin
        state_d = IDLE;
`ifdef MEM_ARB_RR_EN
        last_x_d = (id_q == REQ_EXT) ? 1'b1 : (id_q == REQ_IF) ? 1'b0 : last_x_q;
`endif
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= REQ_NONE;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      d_rdata_q   <= '0;
      x_rdata_q   <= '0;
      if_rdata_q  <= '0;
      d_valid_q   <= 1'b0;
      x_valid_q   <= 1'b0;
      if_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      d_rdata_q   <= d_rdata_d;
      x_rdata_q   <= x_rdata_d;
      if_rdata_q  <= if_rdata_d;
      d_valid_q   <= d_valid_d;
      x_valid_q   <= x_valid_d;
      if_valid_q  <= if_valid_d;
    end
  end
`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) last_x_q <= rst ? 1'b1 : last_x_d;
`endif
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign d_rdata   = d_rdata_q;
  assign x_rdata   = x_rdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign x_valid   = x_valid_q;
  assign if_valid  = if_valid_q;
  assign mem_stall = d_req & ~d_valid_q;
  assign if_stall  = if_req & ~if_valid_q;
endmodule
